// File: rtl/fetch_if.sv
// Fetch-side bundle: control inputs, imem port and the valid/ready handoff to decode.
// Carries fetch_count only when FETCH_PERF_CNT_EN is defined.
interface fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              halted;
    logic              wrapped;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]       fetch_count;
`endif

    modport master (
        input  start, stall, branch_taken, branch_target, imem_instr, instr_ready,
        output imem_addr, instr_out, pc_out, instr_valid, halted, wrapped
`ifdef FETCH_PERF_CNT_EN
        , output fetch_count
`endif
    );

    modport slave (
        output start, stall, branch_taken, branch_target, imem_instr, instr_ready,
        input  imem_addr, instr_out, pc_out, instr_valid, halted, wrapped
`ifdef FETCH_PERF_CNT_EN
        , input fetch_count
`endif
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, registers imem words, hands them to decode.
// Optional saturating transfer counter enabled by FETCH_PERF_CNT_EN.
module fetch_controller #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic              halted_q;
    logic              wrapped_q;
    logic              slot_free;
    logic              xfer;

    assign slot_free = !valid_q || bus.instr_ready;
    assign xfer      = valid_q && bus.instr_ready;

    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.wrapped     = wrapped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr_q   <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state    <= RUN;
                        pc       <= '0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.branch_taken) begin
                        // Redirect wins over stall and squashes the wrong-path word.
                        pc      <= bus.branch_target;
                        valid_q <= 1'b0;
                    end else if (bus.stall) begin
                        if (xfer)
                            valid_q <= 1'b0;
                    end else if (slot_free) begin
                        if (bus.imem_instr == HALT_WORD) begin
                            // Halt word is swallowed; PC parks on its address.
                            state    <= HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            instr_q   <= bus.imem_instr;
                            pc_q      <= pc;
                            valid_q   <= 1'b1;
                            pc        <= pc + ADDR_W'(1);
                            wrapped_q <= &pc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt;
    assign bus.fetch_count = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if ((state == IDLE || state == HALT) && bus.start)
            cnt <= '0;
        else if (xfer && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational 16-word memory model.
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] mem [16];

    fetch_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    fetch_controller #(.ADDR_W(4), .DATA_W(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always_comb bus.imem_instr = mem[bus.imem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        mem[5] = 32'hFFFF_FFFF;
        rst = 1'b1;
        bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 4'd0; bus.instr_ready = 1'b1;
        #12;
        check("rst_valid",  32'(bus.instr_valid), 0);
        check("rst_instr",  bus.instr_out, 0);
        check("rst_pcout",  32'(bus.pc_out), 0);
        check("rst_addr",   32'(bus.imem_addr), 0);
        check("rst_halted", 32'(bus.halted), 0);
        check("rst_wrap",   32'(bus.wrapped), 0);
        @(negedge clk); rst = 1'b0;

        // IDLE ignores branch and captures nothing
        tick(); bus.branch_taken = 1'b1; bus.branch_target = 4'd7;
        tick(); bus.branch_taken = 1'b0;
        check("idle_addr",  32'(bus.imem_addr), 0);
        check("idle_valid", 32'(bus.instr_valid), 0);

        // mem[5] is the halt word but it is reached later; fetch 0..2
        mem[5] = 32'd6;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_valid", 32'(bus.instr_valid), 0);
        tick(); check("f0_instr", bus.instr_out, 1); check("f0_pc", 32'(bus.pc_out), 0);
        check("f0_valid", 32'(bus.instr_valid), 1);
        tick(); check("f1_instr", bus.instr_out, 2); check("f1_pc", 32'(bus.pc_out), 1);
        tick(); check("f2_instr", bus.instr_out, 3); check("f2_pc", 32'(bus.pc_out), 2);

        // Backpressure: output frozen, PC parked
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_instr", bus.instr_out, 3);
            check("bp_pc",    32'(bus.pc_out), 2);
            check("bp_addr",  32'(bus.imem_addr), 3);
        end
        bus.instr_ready = 1'b1;
        tick(); check("bp_resume_instr", bus.instr_out, 4); check("bp_resume_pc", 32'(bus.pc_out), 3);

        // Branch to 9 while stalled
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 4'd9;
        tick(); bus.stall = 1'b0; bus.branch_taken = 1'b0;
        check("br_valid", 32'(bus.instr_valid), 0);
        check("br_addr",  32'(bus.imem_addr), 9);
        tick(); check("br_instr", bus.instr_out, 10); check("br_pc", 32'(bus.pc_out), 9);

        // Walk to the wrap point
        for (int p = 10; p < 15; p++) begin
            tick();
            check("walk_pc",   32'(bus.pc_out), 32'(p));
            check("walk_wrap", 32'(bus.wrapped), 0);
        end
        tick(); check("wrap_pulse", 32'(bus.wrapped), 1); check("wrap_pc15", 32'(bus.pc_out), 15);
        check("wrap_instr", bus.instr_out, 16);
        tick(); check("wrap_clear", 32'(bus.wrapped), 0); check("wrap_pc0", 32'(bus.pc_out), 0);
        check("wrap_instr0", bus.instr_out, 1);

        // Stall with a word being consumed: valid drops, PC holds
        bus.stall = 1'b1;
        tick(); check("stall_valid", 32'(bus.instr_valid), 0); check("stall_addr", 32'(bus.imem_addr), 1);
        tick(); check("stall_addr2", 32'(bus.imem_addr), 1);
        bus.stall = 1'b0;
        tick(); check("stall_rel_instr", bus.instr_out, 2); check("stall_rel_pc", 32'(bus.pc_out), 1);

        // Halt at address 5
        mem[5] = 32'hFFFF_FFFF;
        tick(); check("h_pc2", 32'(bus.pc_out), 2);
        tick(); check("h_pc3", 32'(bus.pc_out), 3);
        tick(); check("h_pc4", 32'(bus.pc_out), 4);
        tick();
        check("halt_flag",  32'(bus.halted), 1);
        check("halt_valid", 32'(bus.instr_valid), 0);
        check("halt_addr",  32'(bus.imem_addr), 5);
        bus.branch_taken = 1'b1; bus.branch_target = 4'd2;
        tick(); bus.branch_taken = 1'b0;
        check("halt_br_addr", 32'(bus.imem_addr), 5);
        check("halt_hold",    32'(bus.halted), 1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("restart_halted", 32'(bus.halted), 0);
        check("restart_addr",   32'(bus.imem_addr), 0);
        check("restart_valid",  32'(bus.instr_valid), 0);
        tick(); check("restart_instr", bus.instr_out, 1); check("restart_pc", 32'(bus.pc_out), 0);
        tick(); check("r1_pc", 32'(bus.pc_out), 1);
        // start while running is ignored
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("run_start_pc", 32'(bus.pc_out), 2);
        tick(); check("r3_pc", 32'(bus.pc_out), 3);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_three", 32'(bus.fetch_count), 3);
`endif

        // Async reset between edges
        rst = 1'b1; #1;
        check("arst_valid", 32'(bus.instr_valid), 0);
        check("arst_instr", bus.instr_out, 0);
        check("arst_pcout", 32'(bus.pc_out), 0);
        check("arst_addr",  32'(bus.imem_addr), 0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_cnt", 32'(bus.fetch_count), 0);
`endif
        @(negedge clk); rst = 1'b0;
        tick(); check("post_rst_valid", 32'(bus.instr_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
